// File: rtl/gly_bram_arb_pkg.sv
// Shared types and constants for the gly_bram two-port arbiter.
// The state encodings, port index type and legal read-latency range live here.
package gly_bram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef logic port_t;

    localparam port_t PORT0 = 1'b0;
    localparam port_t PORT1 = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    function automatic logic rd_latency_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/gly_bram_arb_if.sv
// Bundle of both requester ports plus the BRAM-side bus of the gly_bram arbiter.
// slave = arbiter view, master = requester/BRAM environment view.
interface gly_bram_arb_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic [STRB_WIDTH-1:0] m0_wstrb;
    logic                  m0_gnt;
    logic                  m0_ack;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic [STRB_WIDTH-1:0] m1_wstrb;
    logic                  m1_gnt;
    logic                  m1_ack;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic                  bram_en;
    logic [STRB_WIDTH-1:0] bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_wdata;
    logic [DATA_WIDTH-1:0] bram_rdata;

    logic                  busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        output m0_gnt, m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        output m1_gnt, m1_ack, m1_rdata,
        output bram_en, bram_we, bram_addr, bram_wdata,
        input  bram_rdata,
        output busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        input  m0_gnt, m0_ack, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        input  m1_gnt, m1_ack, m1_rdata,
        input  bram_en, bram_we, bram_addr, bram_wdata,
        output bram_rdata,
        input  busy
    );

endinterface

// File: rtl/gly_bram_arb_pick.sv
// Combinational two-way picker for the gly_bram arbiter.
// GLY_BRAM_ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise port 0 always wins.
module gly_bram_arb_pick
    import gly_bram_arb_pkg::*;
(
    input  logic  i_req0,
    input  logic  i_req1,
`ifdef GLY_BRAM_ARB_ROUND_ROBIN_EN
    input  port_t i_last_gnt,
`endif
    output logic  o_any,
    output port_t o_winner
);

    always_comb begin
        o_any = i_req0 | i_req1;
`ifdef GLY_BRAM_ARB_ROUND_ROBIN_EN
        if (i_req0 && i_req1) begin
            o_winner = (i_last_gnt == PORT0) ? PORT1 : PORT0;
        end else begin
            o_winner = i_req0 ? PORT0 : PORT1;
        end
`else
        o_winner = i_req0 ? PORT0 : PORT1;
`endif
    end

endmodule

// File: rtl/gly_bram_arbiter.sv
// Two-requester arbiter/sequencer for the single-port gly_bram block RAM; all outputs registered.
// Build option: GLY_BRAM_ARB_ROUND_ROBIN_EN (round-robin on contention, else fixed priority port 0).
//
// state | meaning
// IDLE  | no access in flight, requests sampled
// ISSUE | gnt pulse, BRAM enable/strobes driven for one cycle
// WAIT  | read latency countdown, BRAM data registered on last cycle
// RESP  | ack pulse (and read data) to the granted port
module gly_bram_arbiter
    import gly_bram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input logic           ACLK,
    input logic           ARESET,
    gly_bram_arb_if.slave bus
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_ISSUE = 2'(ST_ISSUE);
    localparam logic [1:0] S_WAIT  = 2'(ST_WAIT);
    localparam logic [1:0] S_RESP  = 2'(ST_RESP);

    localparam logic [2:0] CNT_LOAD = 3'(RD_LATENCY - 1);

    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_rd_latency
        $error("gly_bram_arbiter: RD_LATENCY out of range");
    end

    logic [1:0]            r_state;
    logic [2:0]            r_cnt;
    logic                  r_we;
    port_t                 r_port;
    logic                  r_gnt0;
    logic                  r_gnt1;
    logic                  r_ack0;
    logic                  r_ack1;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic                  r_bram_en;
    logic [STRB_WIDTH-1:0] r_bram_we;
    logic [ADDR_WIDTH-1:0] r_bram_addr;
    logic [DATA_WIDTH-1:0] r_bram_wdata;
    logic                  r_busy;

    logic                  w_any;
    port_t                 w_winner;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [STRB_WIDTH-1:0] w_sel_wstrb;

`ifdef GLY_BRAM_ARB_ROUND_ROBIN_EN
    port_t r_last_gnt;

    gly_bram_arb_pick u_pick (
        .i_req0     (bus.m0_req),
        .i_req1     (bus.m1_req),
        .i_last_gnt (r_last_gnt),
        .o_any      (w_any),
        .o_winner   (w_winner)
    );

    // Reset value makes the first contested grant go to port 0.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_last_gnt <= PORT1;
        end else if (r_state == S_IDLE && w_any) begin
            r_last_gnt <= w_winner;
        end
    end
`else
    gly_bram_arb_pick u_pick (
        .i_req0   (bus.m0_req),
        .i_req1   (bus.m1_req),
        .o_any    (w_any),
        .o_winner (w_winner)
    );
`endif

    assign w_sel_we    = (w_winner == PORT0) ? bus.m0_we    : bus.m1_we;
    assign w_sel_addr  = (w_winner == PORT0) ? bus.m0_addr  : bus.m1_addr;
    assign w_sel_wdata = (w_winner == PORT0) ? bus.m0_wdata : bus.m1_wdata;
    assign w_sel_wstrb = (w_winner == PORT0) ? bus.m0_wstrb : bus.m1_wstrb;

    // Pulse outputs default low every cycle; each state only raises what it owns.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_port       <= PORT0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_bram_en    <= 1'b0;
            r_bram_we    <= '0;
            r_bram_addr  <= '0;
            r_bram_wdata <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_bram_en <= 1'b0;
            r_bram_we <= '0;

            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state      <= S_ISSUE;
                        r_busy       <= 1'b1;
                        r_we         <= w_sel_we;
                        r_port       <= w_winner;
                        r_gnt0       <= (w_winner == PORT0);
                        r_gnt1       <= (w_winner == PORT1);
                        r_bram_en    <= 1'b1;
                        r_bram_we    <= w_sel_we ? w_sel_wstrb : '0;
                        r_bram_addr  <= w_sel_addr;
                        r_bram_wdata <= w_sel_wdata;
                    end
                end

                S_ISSUE: begin
                    if (r_we) begin
                        r_state <= S_RESP;
                        r_ack0  <= (r_port == PORT0);
                        r_ack1  <= (r_port == PORT1);
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= CNT_LOAD;
                    end
                end

                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= S_RESP;
                        if (r_port == PORT0) begin
                            r_ack0   <= 1'b1;
                            r_rdata0 <= bus.bram_rdata;
                        end else begin
                            r_ack1   <= 1'b1;
                            r_rdata1 <= bus.bram_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end

                S_RESP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.m0_gnt     = r_gnt0;
    assign bus.m1_gnt     = r_gnt1;
    assign bus.m0_ack     = r_ack0;
    assign bus.m1_ack     = r_ack1;
    assign bus.m0_rdata   = r_rdata0;
    assign bus.m1_rdata   = r_rdata1;
    assign bus.bram_en    = r_bram_en;
    assign bus.bram_we    = r_bram_we;
    assign bus.bram_addr  = r_bram_addr;
    assign bus.bram_wdata = r_bram_wdata;
    assign bus.busy       = r_busy;

endmodule
